hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard unit for the 5-stage MIPS core, placed between the ID-stage decoder and the IF/ID/PC write enables.
- Consumes the decoder's jump_hazard, RegWrite, MemRead and final destination.
- Produces the load_use_hazard bubble request that the decoder consumes.
- Keeps its own registered shadow of the EX and MEM stages to detect RAW hazards, including the two-cycle stall for a load followed by a branch.
- Issues IF/ID flushes for jumps and taken branches, and keeps performance counters.

Parameters:
CNT_W, 32, width of the stall_cycles and flush_count saturating counters.

Ports:
clk  in  1  core clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_reads_early  in  1  ID instruction needs operands in ID (beq, bne, jr, jalr)
dec_reg_write  in  1  decoder RegWrite for the ID instruction
dec_mem_read  in  1  decoder MemRead for the ID instruction
dec_dst  in  5  final destination register after the RegDst mux (31 for jal/jalr)
jump_hazard  in  1  decoder jump indication (j, jal, jr, jalr)
branch_taken  in  1  ID-stage branch comparator result, qualified by beq/bne
load_use_hazard  out  1  bubble request to the decoder; also "stall"
pc_write  out  1  PC register enable
if_id_write  out  1  IF/ID register enable
if_id_flush  out  1  zero the IF/ID register at the next edge
stall_cause  out  2  0 none, 1 load-use, 2 branch-after-ALU, 3 branch-after-load
stall_cycles  out  CNT_W  saturating count of stalled cycles
flush_count  out  CNT_W  saturating count of flushes

Behaviour:
Shadow registers (reset value 0):
- EX stage: ex_rw, ex_mr, ex_dst[4:0].
- MEM stage: mem_rw, mem_mr, mem_dst[4:0].
- Per edge: mem_* <= ex_*.
- Per edge: ex_* <= stall ? 0 : {dec_reg_write, dec_mem_read, dec_dst}. Stall inserts a bubble.

Hazard match:
- match(d) = d!=0 && ((id_uses_rs && id_rs==d) || (id_uses_rt && id_rt==d)).
- Register 0 never causes a hazard.

Hazard conditions, combinational from shadow registers and id_* only:
- H1 = ex_mr && match(ex_dst).
- H2 = id_reads_early && ex_rw && !ex_mr && match(ex_dst).
- H3 = id_reads_early && mem_mr && match(mem_dst).
- stall = H1 | H2 | H3.
- Priority for stall_cause: H1 > H3 > H2.
- dec_* must not feed stall combinationally; this avoids a loop through the decoder.

Outputs:
- load_use_hazard = stall.
- pc_write = if_id_write = ~stall.
- if_id_flush = ~stall && (jump_hazard || branch_taken).
- A jump or branch seen during a stall is ignored until the stall clears; its operands are not yet valid.

Resulting sequences:
- lw followed by a dependent ALU op: 1-cycle stall.
- ALU op followed by a dependent early reader: 1-cycle stall.
- lw followed by a dependent early reader: 2 consecutive stall cycles (H1, then H3), then proceed.

Counters:
- stall_cycles increments on every stall cycle; flush_count increments on every cycle with if_id_flush=1.
- Both saturate at all-ones with no wrap.

Reset:
- Asserting reset_n clears all registers and counters immediately, including mid-stall.
- While reset_n=0, outputs are forced: load_use_hazard=0, pc_write=1, if_id_write=1, if_id_flush=0, stall_cause=0.
- First cycle after release: no hazard possible, because the shadows are zero.

Simultaneous stall and jump_hazard:
- Stall wins. PC and IF/ID are held, no flush occurs.
- The flush happens in the first non-stall cycle in which the decoder still presents the jump.

Decomposition:
- Package core_pkg: REG_ZERO=5'd0, REG_RA=5'd31, stall_cause encodings (CAUSE_NONE, CAUSE_LOAD_USE, CAUSE_BR_ALU, CAUSE_BR_LOAD), and the opcode/funct constants shared with the decoder.
- One sub-module, sat_counter: parameter W, ports clk, reset_n, inc, count. Instantiated twice.

Test Plan:
- lw $2 (dec_mem_read=1, dec_dst=2), then add with id_rs=2 -> load_use_hazard=1, stall_cause=1, pc_write=0 for exactly 1 cycle; ex_* bubble observed; stall_cycles=1.
- addi $3, then beq with id_reads_early=1, id_rt=3 -> 1 stall cycle, cause=2; next cycle branch_taken=1 -> if_id_flush=1, flush_count=1.
- lw $4, then bne reading $4 -> 2 stall cycles (cause 1 then 3), then proceed; stall_cycles=2.
- Writer to $0 (dec_dst=0, dec_mem_read=1), then a reader of $0 -> no stall; j with jump_hazard=1 -> if_id_flush=1 for 1 cycle, pc_write=1.
- jr $5 one cycle after lw $5 -> jump_hazard high throughout, if_id_flush=0 during both stall cycles, then 1 in the third cycle.
- Deassert reset_n in the second stall cycle of a lw/bne pair -> outputs at reset values immediately and counters 0; after release, the same ID inputs produce no stall.
- CNT_W=4 with 20 stall cycles -> stall_cycles holds 15.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants and types for the 5-stage MIPS core: register
// aliases, hazard-unit stall cause encodings and the opcode/funct
// values the decoder and hazard unit agree on.
package core_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_LOAD_USE = 2'd1,
    CAUSE_BR_ALU   = 2'd2,
    CAUSE_BR_LOAD  = 2'd3
  } stall_cause_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  // True when a producer writing register d feeds an operand the ID
  // instruction actually reads; $0 is hardwired and never a dependency.
  function automatic logic reg_match(input logic [4:0] d,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rs,
                                     input logic       uses_rt);
    return (d != REG_ZERO) && ((uses_rs && (rs == d)) || (uses_rt && (rt == d)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Count qualified events, holding once the maximum value is reached.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: tracks what the EX and MEM stages will write,
// requests bubbles for RAW hazards the forwarding network cannot cover,
// and flushes IF/ID when a jump or taken branch resolves in ID.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_reads_early,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic [4:0]       dec_dst,
  input  logic             jump_hazard,
  input  logic             branch_taken,
  output logic             load_use_hazard,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic [1:0]       stall_cause,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // Shadow of the EX stage, and of the MEM stage. The MEM shadow keeps only
  // what hazard detection looks at: a load there still blocks early readers,
  // while a plain ALU result there is already forwardable to ID.
  logic       ex_rw;
  logic       ex_mr;
  logic [4:0] ex_dst;
  logic       mem_mr;
  logic [4:0] mem_dst;

  logic         h_load_use;
  logic         h_br_alu;
  logic         h_br_load;
  logic         stall;
  logic         flush;
  stall_cause_e cause;

  // Hazard detection looks only at the shadows and ID operand fields, never
  // at dec_*, so the bubble request cannot loop back through the decoder.
  always_comb begin
    h_load_use = ex_mr && reg_match(ex_dst, id_rs, id_rt, id_uses_rs, id_uses_rt);
    h_br_alu   = id_reads_early && ex_rw && !ex_mr &&
                 reg_match(ex_dst, id_rs, id_rt, id_uses_rs, id_uses_rt);
    h_br_load  = id_reads_early && mem_mr &&
                 reg_match(mem_dst, id_rs, id_rt, id_uses_rs, id_uses_rt);
    stall      = reset_n && (h_load_use || h_br_alu || h_br_load);
    flush      = reset_n && !stall && (jump_hazard || branch_taken);
    cause      = CAUSE_NONE;
    if (stall) begin
      if (h_load_use) begin
        cause = CAUSE_LOAD_USE;
      end else if (h_br_load) begin
        cause = CAUSE_BR_LOAD;
      end else begin
        cause = CAUSE_BR_ALU;
      end
    end
  end

  assign load_use_hazard = stall;
  assign pc_write        = ~stall;
  assign if_id_write     = ~stall;
  assign if_id_flush     = flush;
  assign stall_cause     = cause;

  // Advance the stage shadows; a stall pushes a bubble into EX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_rw   <= 1'b0;
      ex_mr   <= 1'b0;
      ex_dst  <= REG_ZERO;
      mem_mr  <= 1'b0;
      mem_dst <= REG_ZERO;
    end else begin
      mem_mr  <= ex_mr;
      mem_dst <= ex_dst;
      if (stall) begin
        ex_rw  <= 1'b0;
        ex_mr  <= 1'b0;
        ex_dst <= REG_ZERO;
      end else begin
        ex_rw  <= dec_reg_write;
        ex_mr  <= dec_mem_read;
        ex_dst <= dec_dst;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stall),
    .count   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (flush),
    .count   (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by a
// randomized run against an in-flight instruction model.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [4:0]       id_rs = '0;
  logic [4:0]       id_rt = '0;
  logic             id_uses_rs = 1'b0;
  logic             id_uses_rt = 1'b0;
  logic             id_reads_early = 1'b0;
  logic             dec_reg_write = 1'b0;
  logic             dec_mem_read = 1'b0;
  logic [4:0]       dec_dst = '0;
  logic             jump_hazard = 1'b0;
  logic             branch_taken = 1'b0;
  logic             load_use_hazard;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic [1:0]       stall_cause;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  int vectors = 0;
  int miscompares = 0;

  // An issued instruction as the model sees it; bubbles are all-zero.
  typedef struct packed {
    logic       rw;
    logic       mr;
    logic [4:0] dst;
  } slot_t;

  slot_t in_flight[$];
  int    m_stalls;
  int    m_flushes;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_reads_early  (id_reads_early),
    .dec_reg_write   (dec_reg_write),
    .dec_mem_read    (dec_mem_read),
    .dec_dst         (dec_dst),
    .jump_hazard     (jump_hazard),
    .branch_taken    (branch_taken),
    .load_use_hazard (load_use_hazard),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .stall_cause     (stall_cause),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic early,
                        input logic rw, input logic mr, input logic [4:0] dst,
                        input logic jmp, input logic br);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_reads_early = early; dec_reg_write = rw; dec_mem_read = mr;
    dec_dst = dst; jump_hazard = jmp; branch_taken = br;
  endtask

  task automatic idle();
    set_id(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    in_flight = {};
    in_flight.push_back('0);
    in_flight.push_back('0);
    m_stalls = 0;
    m_flushes = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    model_reset();
    #1;
  endtask

  function automatic bit reads(input logic [4:0] d);
    return d != 5'd0 && ((id_uses_rs && id_rs == d) || (id_uses_rt && id_rt == d));
  endfunction

  task automatic test_reset();
    set_id(5'd2, 5'd2, 1, 1, 1, 1, 1, 5'd2, 1, 1);
    reset_n = 1'b0;
    #7;
    vectors += 6;
    if (load_use_hazard !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_stall: got %0d want 0", load_use_hazard); end
    if (pc_write !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_pc_write: got %0d want 1", pc_write); end
    if (if_id_write !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_if_id_write: got %0d want 1", if_id_write); end
    if (if_id_flush !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_flush: got %0d want 0", if_id_flush); end
    if (stall_cause !== 2'd0) begin miscompares++; $display("[TB] FAIL rst_cause: got %0d want 0", stall_cause); end
    if (stall_cycles !== '0 || flush_count !== '0) begin miscompares++; $display("[TB] FAIL rst_counters: got %0d/%0d want 0/0", stall_cycles, flush_count); end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(5'd0, 5'd0, 0, 0, 0, 1, 1, 5'd2, 0, 0); #1;
    vectors++;
    if (load_use_hazard !== 1'b0) begin miscompares++; $display("[TB] FAIL lu_lw_issue: got %0d want 0", load_use_hazard); end
    tick();
    set_id(5'd2, 5'd9, 1, 1, 0, 1, 0, 5'd7, 0, 0); #1;
    vectors += 3;
    if (load_use_hazard !== 1'b1) begin miscompares++; $display("[TB] FAIL lu_stall: got %0d want 1", load_use_hazard); end
    if (stall_cause !== 2'd1) begin miscompares++; $display("[TB] FAIL lu_cause: got %0d want 1", stall_cause); end
    if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin miscompares++; $display("[TB] FAIL lu_enables: got %0d/%0d want 0/0", pc_write, if_id_write); end
    tick(); #1;
    vectors += 2;
    if (load_use_hazard !== 1'b0 || pc_write !== 1'b1) begin miscompares++; $display("[TB] FAIL lu_release: got stall=%0d pc=%0d want 0/1", load_use_hazard, pc_write); end
    if (stall_cycles !== 4'd1) begin miscompares++; $display("[TB] FAIL lu_stall_cycles: got %0d want 1", stall_cycles); end
    tick();
  endtask

  task automatic test_branch_alu();
    do_reset();
    set_id(5'd1, 5'd0, 1, 0, 0, 1, 0, 5'd3, 0, 0); tick();
    set_id(5'd1, 5'd3, 1, 1, 1, 0, 0, 5'd0, 0, 0); #1;
    vectors += 2;
    if (load_use_hazard !== 1'b1 || stall_cause !== 2'd2) begin miscompares++; $display("[TB] FAIL bra_stall: got %0d cause %0d want 1 cause 2", load_use_hazard, stall_cause); end
    if (if_id_flush !== 1'b0) begin miscompares++; $display("[TB] FAIL bra_no_flush: got %0d want 0", if_id_flush); end
    tick();
    branch_taken = 1'b1; #1;
    vectors++;
    if (load_use_hazard !== 1'b0 || if_id_flush !== 1'b1) begin miscompares++; $display("[TB] FAIL bra_taken: got stall=%0d flush=%0d want 0/1", load_use_hazard, if_id_flush); end
    tick(); idle(); #1;
    vectors += 2;
    if (flush_count !== 4'd1) begin miscompares++; $display("[TB] FAIL bra_flush_count: got %0d want 1", flush_count); end
    if (stall_cycles !== 4'd1) begin miscompares++; $display("[TB] FAIL bra_stall_cycles: got %0d want 1", stall_cycles); end
  endtask

  task automatic test_branch_load();
    do_reset();
    set_id(5'd0, 5'd0, 0, 0, 0, 1, 1, 5'd4, 0, 0); tick();
    set_id(5'd4, 5'd8, 1, 1, 1, 0, 0, 5'd0, 0, 0); #1;
    vectors++;
    if (load_use_hazard !== 1'b1 || stall_cause !== 2'd1) begin miscompares++; $display("[TB] FAIL brl_first: got %0d cause %0d want 1 cause 1", load_use_hazard, stall_cause); end
    tick(); #1;
    vectors++;
    if (load_use_hazard !== 1'b1 || stall_cause !== 2'd3) begin miscompares++; $display("[TB] FAIL brl_second: got %0d cause %0d want 1 cause 3", load_use_hazard, stall_cause); end
    tick(); #1;
    vectors += 2;
    if (load_use_hazard !== 1'b0 || stall_cause !== 2'd0) begin miscompares++; $display("[TB] FAIL brl_proceed: got %0d cause %0d want 0 cause 0", load_use_hazard, stall_cause); end
    if (stall_cycles !== 4'd2) begin miscompares++; $display("[TB] FAIL brl_stall_cycles: got %0d want 2", stall_cycles); end
    tick();
  endtask

  task automatic test_reg_zero();
    do_reset();
    set_id(5'd0, 5'd0, 0, 0, 0, 1, 1, 5'd0, 0, 0); tick();
    set_id(5'd0, 5'd0, 1, 1, 1, 1, 0, 5'd0, 0, 0); #1;
    vectors++;
    if (load_use_hazard !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_no_stall: got %0d want 0", load_use_hazard); end
    tick();
    set_id(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 1, 0); #1;
    vectors++;
    if (if_id_flush !== 1'b1 || pc_write !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_jump: got flush=%0d pc=%0d want 1/1", if_id_flush, pc_write); end
    tick(); idle(); #1;
    vectors++;
    if (if_id_flush !== 1'b0 || flush_count !== 4'd1) begin miscompares++; $display("[TB] FAIL zero_jump_once: got flush=%0d count=%0d want 0/1", if_id_flush, flush_count); end
  endtask

  task automatic test_jr_after_load();
    do_reset();
    set_id(5'd0, 5'd0, 0, 0, 0, 1, 1, 5'd5, 0, 0); tick();
    set_id(5'd5, 5'd0, 1, 0, 1, 0, 0, 5'd0, 1, 0); #1;
    vectors++;
    if (load_use_hazard !== 1'b1 || if_id_flush !== 1'b0) begin miscompares++; $display("[TB] FAIL jr_stall1: got stall=%0d flush=%0d want 1/0", load_use_hazard, if_id_flush); end
    tick(); #1;
    vectors++;
    if (load_use_hazard !== 1'b1 || if_id_flush !== 1'b0) begin miscompares++; $display("[TB] FAIL jr_stall2: got stall=%0d flush=%0d want 1/0", load_use_hazard, if_id_flush); end
    tick(); #1;
    vectors++;
    if (if_id_flush !== 1'b1 || pc_write !== 1'b1) begin miscompares++; $display("[TB] FAIL jr_flush: got flush=%0d pc=%0d want 1/1", if_id_flush, pc_write); end
    tick(); idle(); #1;
    vectors++;
    if (flush_count !== 4'd1 || stall_cycles !== 4'd2) begin miscompares++; $display("[TB] FAIL jr_counters: got %0d/%0d want 1/2", flush_count, stall_cycles); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(5'd0, 5'd0, 0, 0, 0, 1, 1, 5'd4, 0, 0); tick();
    set_id(5'd4, 5'd0, 1, 0, 1, 0, 0, 5'd0, 0, 0); tick(); #1;
    vectors++;
    if (stall_cause !== 2'd3 || stall_cycles !== 4'd1) begin miscompares++; $display("[TB] FAIL mid_pre: got cause=%0d cycles=%0d want 3/1", stall_cause, stall_cycles); end
    reset_n = 1'b0; #1;
    vectors += 2;
    if (load_use_hazard !== 1'b0 || pc_write !== 1'b1 || stall_cause !== 2'd0) begin miscompares++; $display("[TB] FAIL mid_outputs: got stall=%0d pc=%0d cause=%0d want 0/1/0", load_use_hazard, pc_write, stall_cause); end
    if (stall_cycles !== 4'd0) begin miscompares++; $display("[TB] FAIL mid_counter: got %0d want 0", stall_cycles); end
    @(posedge clk); #3 reset_n = 1'b1; #1;
    vectors++;
    if (load_use_hazard !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_after_release: got %0d want 0", load_use_hazard); end
    tick(); idle();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_id(5'd0, 5'd0, 0, 0, 0, 1, 1, 5'd6, 0, 0); tick();
      set_id(5'd6, 5'd6, 1, 1, 1, 0, 0, 5'd0, 0, 0); tick(); tick(); tick();
    end
    idle(); #1;
    vectors++;
    if (stall_cycles !== 4'd15) begin miscompares++; $display("[TB] FAIL sat_hold: got %0d want 15", stall_cycles); end
  endtask

  task automatic test_random();
    int    exp_cause;
    bit    exp_stall, exp_flush, ld1, alu1, ld2;
    slot_t newer, older, issued;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0));
      #1;
      newer = in_flight[0];
      older = in_flight[1];
      ld1  = newer.mr && reads(newer.dst);
      alu1 = id_reads_early && newer.rw && !newer.mr && reads(newer.dst);
      ld2  = id_reads_early && older.mr && reads(older.dst);
      exp_cause = ld1 ? 1 : (ld2 ? 3 : (alu1 ? 2 : 0));
      exp_stall = exp_cause != 0;
      exp_flush = !exp_stall && (jump_hazard || branch_taken);
      vectors += 4;
      if (load_use_hazard !== exp_stall) begin miscompares++; $display("[TB] FAIL rnd_stall@%0d: got %0d want %0d", n, load_use_hazard, exp_stall); end
      if (stall_cause !== 2'(exp_cause)) begin miscompares++; $display("[TB] FAIL rnd_cause@%0d: got %0d want %0d", n, stall_cause, exp_cause); end
      if (pc_write !== !exp_stall || if_id_write !== !exp_stall) begin miscompares++; $display("[TB] FAIL rnd_enables@%0d: got %0d/%0d want %0d", n, pc_write, if_id_write, !exp_stall); end
      if (if_id_flush !== exp_flush) begin miscompares++; $display("[TB] FAIL rnd_flush@%0d: got %0d want %0d", n, if_id_flush, exp_flush); end
      issued.rw = dec_reg_write; issued.mr = dec_mem_read; issued.dst = dec_dst;
      in_flight.push_front(exp_stall ? slot_t'('0) : issued);
      void'(in_flight.pop_back());
      if (exp_stall && m_stalls < CNT_MAX) m_stalls++;
      if (exp_flush && m_flushes < CNT_MAX) m_flushes++;
      tick();
      vectors++;
      if (stall_cycles !== 4'(m_stalls) || flush_count !== 4'(m_flushes)) begin miscompares++; $display("[TB] FAIL rnd_counters@%0d: got %0d/%0d want %0d/%0d", n, stall_cycles, flush_count, m_stalls, m_flushes); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_branch_alu();
    test_branch_load();
    test_reg_zero();
    test_jr_after_load();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
